// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selection codes and transmitter FSM
// encodings. The planned parametrised receiver uses the same package.
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data. rd_data updates only on a pop
// and holds its value until the next pop, so the consumer can use it for as
// long as it needs the word.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_wr;
   logic             do_rd;

   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign level = count;

   // Storage array write port.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Registered read port: the popped entry appears on rd_data after the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (do_rd) begin
         rd_data <= mem[rd_ptr];
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: stream words into a FIFO, serialise LSB-first.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line high, waiting for a word in the FIFO
// ST_START  | start bit (low); popped word arrives on the FIFO read port
// ST_DATA   | DATA_W data bits, bit 0 first
// ST_PARITY | parity bit, only when even/odd parity was latched
// ST_STOP   | one or two stop bits; last clock pops the next word if any
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [DIV_W-1:0]                cfg_div,
   input  logic [1:0]                      cfg_parity,
   input  logic                            cfg_stop2,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic [DATA_W-1:0]               s_data,
   output logic                            uart_tx,
   output logic                            tx_busy,
   output logic                            tx_done,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

   localparam int BW = $clog2(DATA_W);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   uart_state_t       state, state_d;
   logic [DIV_W-1:0]  baud_cnt, baud_cnt_d;
   logic [BW-1:0]     bit_cnt, bit_cnt_d;
   logic              stop_idx, stop_idx_d;
   logic [DATA_W-1:0] shreg, shreg_d;
   logic              tx_q, tx_d;
   logic              done_q, done_d;
   logic              pop;
   logic              cfg_load;

   logic [DIV_W-1:0]  div_q;
   logic [1:0]        par_q;
   logic              stop2_q;

   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_rd_data;
   logic              par_en;
   logic              par_bit;

   // A divisor of 0 would give a 1-clock bit; clamp it to 1 (2 clocks/bit).
   function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
      return (d == '0) ? DIV_W'(1) : d;
   endfunction

   assign s_ready    = !rst && !fifo_full;
   assign uart_tx    = tx_q;
   assign tx_done    = done_q;
   assign tx_busy    = (state != ST_IDLE);

   // The FIFO read register holds the current frame's word until the next pop.
   assign par_en  = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
   assign par_bit = (par_q == PAR_ODD) ? ~^fifo_rd_data : ^fifo_rd_data;

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (s_valid && s_ready),
      .wr_data (s_data),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // State, counters, registered line output and per-frame config latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         stop_idx <= 1'b0;
         shreg    <= '0;
         tx_q     <= 1'b1;
         done_q   <= 1'b0;
         div_q    <= DIV_W'(1);
         par_q    <= PAR_NONE;
         stop2_q  <= 1'b0;
      end else begin
         state    <= state_d;
         baud_cnt <= baud_cnt_d;
         bit_cnt  <= bit_cnt_d;
         stop_idx <= stop_idx_d;
         shreg    <= shreg_d;
         tx_q     <= tx_d;
         done_q   <= done_d;
         if (cfg_load) begin
            div_q   <= eff_div(cfg_div);
            par_q   <= cfg_parity;
            stop2_q <= cfg_stop2;
         end
      end
   end

   // Next-state logic; baud_cnt == 0 marks the last clock of each bit.
   always_comb begin
      state_d    = state;
      baud_cnt_d = baud_cnt;
      bit_cnt_d  = bit_cnt;
      stop_idx_d = stop_idx;
      shreg_d    = shreg;
      tx_d       = tx_q;
      done_d     = 1'b0;
      pop        = 1'b0;
      cfg_load   = 1'b0;

      case (state)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               pop        = 1'b1;
               cfg_load   = 1'b1;
               state_d    = ST_START;
               baud_cnt_d = eff_div(cfg_div);
               tx_d       = 1'b0;
            end
         end

         ST_START: begin
            if (baud_cnt == '0) begin
               state_d    = ST_DATA;
               baud_cnt_d = div_q;
               bit_cnt_d  = '0;
               shreg_d    = fifo_rd_data;
               tx_d       = fifo_rd_data[0];
            end else begin
               baud_cnt_d = baud_cnt - DIV_W'(1);
            end
         end

         ST_DATA: begin
            if (baud_cnt == '0) begin
               baud_cnt_d = div_q;
               if (bit_cnt == LAST_BIT) begin
                  if (par_en) begin
                     state_d = ST_PARITY;
                     tx_d    = par_bit;
                  end else begin
                     state_d    = ST_STOP;
                     stop_idx_d = 1'b0;
                     tx_d       = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt + BW'(1);
                  shreg_d   = shreg >> 1;
                  tx_d      = shreg[1];
               end
            end else begin
               baud_cnt_d = baud_cnt - DIV_W'(1);
            end
         end

         ST_PARITY: begin
            if (baud_cnt == '0) begin
               state_d    = ST_STOP;
               baud_cnt_d = div_q;
               stop_idx_d = 1'b0;
               tx_d       = 1'b1;
            end else begin
               baud_cnt_d = baud_cnt - DIV_W'(1);
            end
         end

         ST_STOP: begin
            if (baud_cnt == '0) begin
               if (stop2_q && !stop_idx) begin
                  stop_idx_d = 1'b1;
                  baud_cnt_d = div_q;
               end else begin
                  done_d = 1'b1;
                  if (!fifo_empty) begin
                     pop        = 1'b1;
                     cfg_load   = 1'b1;
                     state_d    = ST_START;
                     baud_cnt_d = eff_div(cfg_div);
                     tx_d       = 1'b0;
                  end else begin
                     state_d = ST_IDLE;
                     tx_d    = 1'b1;
                  end
               end
            end else begin
               baud_cnt_d = baud_cnt - DIV_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: directed and randomised frames compared against
// a frame model built from the serial format rules.
module tb_uart_tx_fifo;

   logic        clk;
   logic        rst;
   logic [15:0] cfg_div;
   logic [1:0]  cfg_parity;
   logic        cfg_stop2;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_data;
   logic        uart_tx;
   logic        tx_busy;
   logic        tx_done;
   logic [4:0]  fifo_level;

   int checks   = 0;
   int failures = 0;

   uart_tx_fifo #(
      .DATA_W     (8),
      .FIFO_DEPTH (16),
      .DIV_W      (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_div    (cfg_div),
      .cfg_parity (cfg_parity),
      .cfg_stop2  (cfg_stop2),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .uart_tx    (uart_tx),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .fifo_level (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push1(input logic [7:0] w);
      s_valid = 1'b1;
      s_data  = w;
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   // Checks one frame sample-by-sample. elapsed>0 means that many samples of
   // the frame have already gone by; new_div>=0 changes cfg_div mid-frame.
   task automatic expect_frame(input logic [7:0] w, input int div, input logic [1:0] par,
                               input logic st2, input int wait_max, input int elapsed,
                               input int new_div, input string tag);
      logic bits[$];
      int   per;
      int   total;
      int   n;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(w[i]);
      if (par == 2'b01) bits.push_back(^w);
      else if (par == 2'b10) bits.push_back(~^w);
      bits.push_back(1'b1);
      if (st2) bits.push_back(1'b1);
      per   = ((div == 0) ? 1 : div) + 1;
      total = bits.size() * per;
      if (elapsed == 0) begin
         n = 0;
         while (uart_tx !== 1'b0 && n < wait_max) begin
            @(negedge clk);
            n++;
         end
         chk({tag, "_start_seen"}, uart_tx, 0);
      end
      for (int s = elapsed; s < total; s++) begin
         if (new_div >= 0 && s == 2 * per + 1) cfg_div = 16'(new_div);
         chk($sformatf("%s_line_bit%0d", tag, s / per), uart_tx, bits[s / per]);
         chk({tag, "_busy"}, tx_busy, 1);
         if (s > 0) chk({tag, "_done_early"}, tx_done, 0);
         @(negedge clk);
      end
      chk({tag, "_done_end"}, tx_done, 1);
   endtask

   initial begin
      logic [7:0] w;
      logic [7:0] q[$];
      int         d;
      logic [1:0] p;
      logic       st;

      rst        = 1'b1;
      cfg_div    = 16'd3;
      cfg_parity = 2'b00;
      cfg_stop2  = 1'b0;
      s_valid    = 1'b0;
      s_data     = 8'h00;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_s_ready_low", s_ready, 0);
      chk("rst_tx_idle", uart_tx, 1);
      chk("rst_busy", tx_busy, 0);
      chk("rst_done", tx_done, 0);
      chk("rst_level", fifo_level, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_s_ready", s_ready, 1);

      // Single byte 0x99, no parity, one stop
      push1(8'h99);
      expect_frame(8'h99, 3, 2'b00, 1'b0, 4, 0, -1, "single");
      chk("single_idle_busy", tx_busy, 0);
      @(negedge clk);
      chk("single_idle_line", uart_tx, 1);
      chk("single_done_pulse", tx_done, 0);

      // Parity: even, odd, odd with two stop bits
      cfg_parity = 2'b01;
      push1(8'h07);
      expect_frame(8'h07, 3, 2'b01, 1'b0, 4, 0, -1, "par_even");
      cfg_parity = 2'b10;
      push1(8'h07);
      expect_frame(8'h07, 3, 2'b10, 1'b0, 4, 0, -1, "par_odd");
      cfg_stop2 = 1'b1;
      push1(8'h07);
      expect_frame(8'h07, 3, 2'b10, 1'b1, 4, 0, -1, "par_stop2");
      cfg_parity = 2'b00;
      cfg_stop2  = 1'b0;

      // Back-to-back frames, no idle gap
      s_valid = 1'b1;
      s_data  = 8'hA5;
      @(negedge clk);
      s_data  = 8'h3C;
      @(negedge clk);
      s_valid = 1'b0;
      expect_frame(8'hA5, 3, 2'b00, 1'b0, 4, 0, -1, "b2b_first");
      expect_frame(8'h3C, 3, 2'b00, 1'b0, 0, 0, -1, "b2b_second");
      chk("b2b_idle_busy", tx_busy, 0);

      // Full FIFO at cfg_div=99
      cfg_div = 16'd99;
      for (int i = 0; i < 18; i++) begin
         w       = 8'($urandom);
         s_valid = 1'b1;
         s_data  = w;
         if (i == 16) chk("full_level15", fifo_level, 15);
         if (i == 17) chk("full_level16", fifo_level, 16);
         chk($sformatf("full_s_ready_c%0d", i + 1), s_ready, (i < 17) ? 1 : 0);
         if (i < 17) q.push_back(w);
         @(negedge clk);
      end
      s_valid = 1'b0;
      expect_frame(q[0], 99, 2'b00, 1'b0, 0, 16, -1, "full_w0");
      for (int k = 1; k < 17; k++) begin
         expect_frame(q[k], 99, 2'b00, 1'b0, 0, 0, -1, $sformatf("full_w%0d", k));
      end
      chk("full_drained_level", fifo_level, 0);
      chk("full_drained_busy", tx_busy, 0);

      // Reset during data bit 3 with a word still queued
      cfg_div = 16'd3;
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      @(negedge clk);
      s_data  = 8'($urandom);
      @(negedge clk);
      s_valid = 1'b0;
      chk("midrst_line_low", uart_tx, 0);
      repeat (17) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_s_ready", s_ready, 0);
      rst = 1'b0;
      chk("midrst_line", uart_tx, 1);
      chk("midrst_level", fifo_level, 0);
      chk("midrst_busy", tx_busy, 0);
      chk("midrst_done", tx_done, 0);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("midrst_abandon_line", uart_tx, 1);
         chk("midrst_abandon_done", tx_done, 0);
      end
      push1(8'h55);
      expect_frame(8'h55, 3, 2'b00, 1'b0, 4, 0, -1, "midrst_next");

      // Config change mid-frame applies to the next frame only
      w = 8'($urandom);
      s_valid = 1'b1;
      s_data  = 8'hC3;
      @(negedge clk);
      s_data  = w;
      @(negedge clk);
      s_valid = 1'b0;
      expect_frame(8'hC3, 3, 2'b00, 1'b0, 4, 0, 7, "cfgchg_cur");
      expect_frame(w, 7, 2'b00, 1'b0, 0, 0, -1, "cfgchg_next");
      cfg_div = 16'd0;
      w = 8'($urandom);
      push1(w);
      expect_frame(w, 0, 2'b00, 1'b0, 4, 0, -1, "div_zero");

      // Randomised configurations, including the reserved parity code
      for (int r = 0; r < 8; r++) begin
         d  = int'($urandom_range(0, 5));
         p  = 2'($urandom_range(0, 3));
         st = 1'($urandom_range(0, 1));
         w  = 8'($urandom);
         cfg_div    = 16'(d);
         cfg_parity = p;
         cfg_stop2  = st;
         push1(w);
         expect_frame(w, d, p, st, 4, 0, -1, $sformatf("rand%0d", r));
      end
      chk("final_level", fifo_level, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
